reg_file_2r1w: RTL and testbench

Parametrised register file with one write port and two independent read ports. It supports per-byte write strobes, registered reads with a valid flag, configurable read-during-write bypass and out-of-range address detection. It replaces the single-port read/write register file in the datapath wherever two operands must be fetched in the same cycle as a result is written back.

---
 rtl/reg_file_2r1w_if.sv | 38 +++
 rtl/reg_file_2r1w.sv | 80 ++++++++
 tb/tb_reg_file_2r1w.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for the two-read/one-write register file: write port, two read
// ports, and the sticky address-error flag with its clear.
interface reg_file_2r1w_if #(
   parameter int MEM_WIDTH = 16,
   parameter int MEM_DEPTH = 8
);
   localparam int ADDR_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int STRB_WIDTH = MEM_WIDTH / 8;

   // No backpressure: every request is taken on the edge that samples it.
   // RdValidN is the only completion signal, a one-cycle pulse per legal read.
   logic                  WrEn;
   logic [ADDR_WIDTH-1:0] WrAddr;
   logic [MEM_WIDTH-1:0]  WrData;
   logic [STRB_WIDTH-1:0] WrStrb;
   logic                  RdEn0;
   logic [ADDR_WIDTH-1:0] RdAddr0;
   logic                  RdEn1;
   logic [ADDR_WIDTH-1:0] RdAddr1;
   logic [MEM_WIDTH-1:0]  RdData0;
   logic [MEM_WIDTH-1:0]  RdData1;
   logic                  RdValid0;
   logic                  RdValid1;
   logic                  AddrErr;
   logic                  ErrClr;

   modport master (
      output WrEn, WrAddr, WrData, WrStrb,
      output RdEn0, RdAddr0, RdEn1, RdAddr1, ErrClr,
      input  RdData0, RdData1, RdValid0, RdValid1, AddrErr
   );

   modport slave (
      input  WrEn, WrAddr, WrData, WrStrb,
      input  RdEn0, RdAddr0, RdEn1, RdAddr1, ErrClr,
      output RdData0, RdData1, RdValid0, RdValid1, AddrErr
   );
endinterface

// File: rtl/reg_file_2r1w.sv
// Register file with one byte-strobed write port, two registered read ports,
// optional read-during-write bypass and a sticky out-of-range flag.
module reg_file_2r1w #(
   parameter int MEM_WIDTH = 16,
   parameter int MEM_DEPTH = 8,
   parameter bit BYPASS    = 1'b1
) (
   input logic            CLK,
   input logic            RST_n,
   reg_file_2r1w_if.slave bus
);
   localparam int ADDR_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int STRB_WIDTH = MEM_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

   logic [MEM_WIDTH-1:0]  mem [MEM_DEPTH];
   logic                  wrInRange, rdInRange0, rdInRange1;
   logic                  wrLegal, rdLegal0, rdLegal1, errHit;
   logic [ADDR_WIDTH-1:0] wrIdx, rdIdx0, rdIdx1;
   logic [MEM_WIDTH-1:0]  wrMask, wrMerged, rdNext0, rdNext1;

   always_comb begin
      wrInRange  = {1'b0, bus.WrAddr}  < DEPTH_LIM;
      rdInRange0 = {1'b0, bus.RdAddr0} < DEPTH_LIM;
      rdInRange1 = {1'b0, bus.RdAddr1} < DEPTH_LIM;
      wrLegal    = bus.WrEn  && wrInRange;
      rdLegal0   = bus.RdEn0 && rdInRange0;
      rdLegal1   = bus.RdEn1 && rdInRange1;
      errHit     = (bus.WrEn  && !wrInRange) ||
                   (bus.RdEn0 && !rdInRange0) ||
                   (bus.RdEn1 && !rdInRange1);

      // Clamp indices so an illegal address never selects past the array end.
      wrIdx  = wrInRange  ? bus.WrAddr  : '0;
      rdIdx0 = rdInRange0 ? bus.RdAddr0 : '0;
      rdIdx1 = rdInRange1 ? bus.RdAddr1 : '0;

      wrMask = '0;
      for (int i = 0; i < STRB_WIDTH; i++) begin
         wrMask[8*i +: 8] = {8{bus.WrStrb[i]}};
      end
      wrMerged = (mem[wrIdx] & ~wrMask) | (bus.WrData & wrMask);

      rdNext0 = mem[rdIdx0];
      rdNext1 = mem[rdIdx1];
      if (BYPASS && wrLegal && (bus.WrAddr == bus.RdAddr0)) rdNext0 = wrMerged;
      if (BYPASS && wrLegal && (bus.WrAddr == bus.RdAddr1)) rdNext1 = wrMerged;
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wrLegal) begin
         mem[wrIdx] <= wrMerged;
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         bus.RdData0  <= '0;
         bus.RdData1  <= '0;
         bus.RdValid0 <= 1'b0;
         bus.RdValid1 <= 1'b0;
         bus.AddrErr  <= 1'b0;
      end else begin
         bus.RdValid0 <= rdLegal0;
         bus.RdValid1 <= rdLegal1;
         if (rdLegal0) bus.RdData0 <= rdNext0;
         if (rdLegal1) bus.RdData1 <= rdNext1;
         // A new error in the same cycle as a clear keeps the flag set.
         if (errHit) begin
            bus.AddrErr <= 1'b1;
         end else if (bus.ErrClr) begin
            bus.AddrErr <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench: dut_a is the default build (depth 8, bypass on), dut_b uses
// depth 6 with bypass off; both see the same stimulus.
module tb_reg_file_2r1w;
   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic [1:0]  ws;
      logic        r0;
      logic [2:0]  a0;
      logic        r1;
      logic [2:0]  a1;
      logic [15:0] e0;
      logic        v0;
      logic [15:0] e1;
      logic        v1;
   } vec_t;

   logic CLK = 1'b0;
   logic RST_n = 1'b0;
   int   nCmp = 0;
   int   nErr = 0;
   vec_t vecs[$];

   reg_file_2r1w_if #(.MEM_WIDTH(16), .MEM_DEPTH(8)) ifA ();
   reg_file_2r1w_if #(.MEM_WIDTH(16), .MEM_DEPTH(6)) ifB ();

   reg_file_2r1w #(.MEM_WIDTH(16), .MEM_DEPTH(8), .BYPASS(1'b1)) dut_a (
      .CLK(CLK), .RST_n(RST_n), .bus(ifA)
   );
   reg_file_2r1w #(.MEM_WIDTH(16), .MEM_DEPTH(6), .BYPASS(1'b0)) dut_b (
      .CLK(CLK), .RST_n(RST_n), .bus(ifB)
   );

   always #5 CLK = ~CLK;

   function automatic vec_t mk(input string name, input logic we, input logic [2:0] wa,
                               input logic [15:0] wd, input logic [1:0] ws,
                               input logic r0, input logic [2:0] a0,
                               input logic r1, input logic [2:0] a1,
                               input logic [15:0] e0, input logic v0,
                               input logic [15:0] e1, input logic v1);
      vec_t v;
      v.name = name; v.we = we; v.wa = wa; v.wd = wd; v.ws = ws;
      v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
      v.e0 = e0; v.v0 = v0; v.e1 = e1; v.v1 = v1;
      return v;
   endfunction

   task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [1:0] ws, input logic r0, input logic [2:0] a0,
                        input logic r1, input logic [2:0] a1, input logic ec);
      ifA.WrEn = we; ifA.WrAddr = wa; ifA.WrData = wd; ifA.WrStrb = ws;
      ifA.RdEn0 = r0; ifA.RdAddr0 = a0; ifA.RdEn1 = r1; ifA.RdAddr1 = a1;
      ifA.ErrClr = ec;
      ifB.WrEn = we; ifB.WrAddr = wa; ifB.WrData = wd; ifB.WrStrb = ws;
      ifB.RdEn0 = r0; ifB.RdAddr0 = a0; ifB.RdEn1 = r1; ifB.RdAddr1 = a1;
      ifB.ErrClr = ec;
   endtask

   task automatic idle();
      drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      // Default build, entries zero after reset.
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mk("rst_rd", 0, 0, 16'h0, 2'b00, 1, 3'(i), 1, 3'(7 - i),
                           16'h0000, 1, 16'h0000, 1));
      end
      vecs.push_back(mk("wr0",     1, 0, 16'hFF00, 2'b11, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
      vecs.push_back(mk("wr4",     1, 4, 16'hFF0F, 2'b11, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
      vecs.push_back(mk("dual",    0, 0, 16'h0000, 2'b00, 1, 0, 1, 4, 16'hFF00, 1, 16'hFF0F, 1));
      vecs.push_back(mk("wr2",     1, 2, 16'h1234, 2'b11, 0, 0, 0, 0, 16'hFF00, 0, 16'hFF0F, 0));
      vecs.push_back(mk("wr2lo",   1, 2, 16'hABCD, 2'b01, 0, 0, 0, 0, 16'hFF00, 0, 16'hFF0F, 0));
      vecs.push_back(mk("rd2",     0, 0, 16'h0000, 2'b00, 1, 2, 0, 0, 16'h12CD, 1, 16'hFF0F, 0));
      vecs.push_back(mk("strb0",   1, 2, 16'hFFFF, 2'b00, 1, 2, 0, 0, 16'h12CD, 1, 16'hFF0F, 0));
      vecs.push_back(mk("rd2b",    0, 0, 16'h0000, 2'b00, 1, 2, 0, 0, 16'h12CD, 1, 16'hFF0F, 0));
      vecs.push_back(mk("rdw3",    1, 3, 16'h5A5A, 2'b11, 1, 3, 1, 3, 16'h5A5A, 1, 16'h5A5A, 1));
      vecs.push_back(mk("rd3",     0, 0, 16'h0000, 2'b00, 1, 3, 0, 0, 16'h5A5A, 1, 16'h5A5A, 0));
      vecs.push_back(mk("rd4",     0, 0, 16'h0000, 2'b00, 0, 0, 1, 4, 16'h5A5A, 0, 16'hFF0F, 1));
      vecs.push_back(mk("hold1",   1, 4, 16'h1111, 2'b11, 0, 0, 0, 0, 16'h5A5A, 0, 16'hFF0F, 0));
      vecs.push_back(mk("hold2",   1, 4, 16'h2222, 2'b11, 0, 0, 0, 0, 16'h5A5A, 0, 16'hFF0F, 0));
      vecs.push_back(mk("hold3",   1, 4, 16'h3333, 2'b11, 0, 0, 0, 0, 16'h5A5A, 0, 16'hFF0F, 0));
      vecs.push_back(mk("hold4",   1, 4, 16'h4444, 2'b11, 0, 0, 0, 0, 16'h5A5A, 0, 16'hFF0F, 0));
      vecs.push_back(mk("hold5",   1, 4, 16'h5555, 2'b11, 0, 0, 0, 0, 16'h5A5A, 0, 16'hFF0F, 0));
      vecs.push_back(mk("rd4n",    0, 0, 16'h0000, 2'b00, 0, 0, 1, 4, 16'h5A5A, 0, 16'h5555, 1));
      vecs.push_back(mk("bypstrb", 1, 4, 16'hAA00, 2'b10, 1, 4, 0, 0, 16'hAA55, 1, 16'h5555, 0));

      // Reset state.
      idle();
      repeat (2) tick();
      chk("rst_data0_a", ifA.RdData0, 16'h0);
      chk("rst_valid0_a", ifA.RdValid0, 1'b0);
      chk("rst_err_a", ifA.AddrErr, 1'b0);
      chk("rst_err_b", ifB.AddrErr, 1'b0);
      RST_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ws,
               vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1, 1'b0);
         tick();
         chk({vecs[i].name, "_d0"}, ifA.RdData0, vecs[i].e0);
         chk({vecs[i].name, "_v0"}, ifA.RdValid0, vecs[i].v0);
         chk({vecs[i].name, "_d1"}, ifA.RdData1, vecs[i].e1);
         chk({vecs[i].name, "_v1"}, ifA.RdValid1, vecs[i].v1);
      end
      idle();
      chk("tbl_err_a", ifA.AddrErr, 1'b0);
      // Reads of 6 and 7 during the reset sweep are out of range for depth 6.
      chk("tbl_err_b", ifB.AddrErr, 1'b1);

      // Asynchronous reset in the middle of a cycle.
      #3;
      RST_n = 1'b0;
      #1;
      chk("async_d0_a", ifA.RdData0, 16'h0);
      chk("async_d1_a", ifA.RdData1, 16'h0);
      chk("async_err_b", ifB.AddrErr, 1'b0);
      tick();
      tick();
      RST_n = 1'b1;
      drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd4, 1'b1, 3'd2, 1'b0);
      tick();
      chk("postrst_a4", ifA.RdData0, 16'h0);
      chk("postrst_a2", ifA.RdData1, 16'h0);
      chk("postrst_b4", ifB.RdData0, 16'h0);
      chk("postrst_b2", ifB.RdData1, 16'h0);

      // Read-during-write: bypass build sees new data, non-bypass sees old.
      drive(1'b1, 3'd3, 16'h5A5A, 2'b11, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0);
      tick();
      chk("rdw_bypass_a", ifA.RdData0, 16'h5A5A);
      chk("rdw_nobyp_b", ifB.RdData0, 16'h0000);
      chk("rdw_valid_b", ifB.RdValid0, 1'b1);
      drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0);
      tick();
      chk("rdw_next_a", ifA.RdData0, 16'h5A5A);
      chk("rdw_next_b", ifB.RdData0, 16'h5A5A);

      // Out-of-range write on the depth-6 build.
      drive(1'b1, 3'd7, 16'hBEEF, 2'b11, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      tick();
      chk("oorwr_err", ifB.AddrErr, 1'b1);
      chk("oorwr_v0", ifB.RdValid0, 1'b0);
      drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd0, 1'b1, 3'd1, 1'b0);
      tick();
      chk("oorwr_e0", ifB.RdData0, 16'h0);
      chk("oorwr_e1", ifB.RdData1, 16'h0);
      drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd2, 1'b1, 3'd4, 1'b0);
      tick();
      chk("oorwr_e2", ifB.RdData0, 16'h0);
      chk("oorwr_e4", ifB.RdData1, 16'h0);
      drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd5, 1'b1, 3'd3, 1'b0);
      tick();
      chk("oorwr_e5", ifB.RdData0, 16'h0);
      chk("oorwr_e3", ifB.RdData1, 16'h5A5A);

      // Out-of-range read holds data and gives no valid.
      drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b1, 3'd6, 1'b0);
      tick();
      chk("oorrd_d1", ifB.RdData1, 16'h5A5A);
      chk("oorrd_v1", ifB.RdValid1, 1'b0);
      chk("oorrd_err", ifB.AddrErr, 1'b1);

      // Clear alone, then clear colliding with a new error.
      drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      tick();
      chk("clr_err", ifB.AddrErr, 1'b0);
      idle();
      tick();
      chk("clr_stay", ifB.AddrErr, 1'b0);
      drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b1, 3'd7, 1'b1);
      tick();
      chk("clrset_err", ifB.AddrErr, 1'b1);
      chk("clrset_v1", ifB.RdValid1, 1'b0);
      chk("clrset_d1", ifB.RdData1, 16'h5A5A);
      drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      tick();
      chk("clr2_err", ifB.AddrErr, 1'b0);
      drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0);
      tick();
      chk("oorrd0_err", ifB.AddrErr, 1'b1);
      chk("oorrd0_v0", ifB.RdValid0, 1'b0);
      idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
      $finish;
   end
endmodule
